// File: rtl/inst_fetch_ctl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctl
// Program counter and fetch sequencer sitting between the decoder/ALU flag
// path and the instruction ROM. Provides relative branches, absolute jumps,
// a small hardware call/return stack and IDLE/LOAD/RUN/DONE sequencing.
//
// Ports:
//   clk         : clock, all state changes on the rising edge
//   reset       : asynchronous, active-low reset
//   start       : hold high to load start_addr, release to run
//   start_addr  : first instruction address of the next program
//   branch_en   : conditional relative branch request
//   ALU_flag    : branch condition from the ALU
//   jump_en     : unconditional absolute jump to target
//   call_en     : push PC+1 and jump to target
//   ret_en      : pop return address into PC
//   halt        : stop the program and freeze the PC
//   target      : signed branch offset or absolute address
//   prog_ctr    : current PC, drives the instruction ROM address
//   done        : high while the program is finished
//   stack_ovf   : sticky, call attempted with a full stack
//   stack_unf   : sticky, return attempted with an empty stack
//   br_count    : (IFETCH_BRCOUNT_EN only) saturating count of taken
//                 control transfers since the last start or reset
//
// Optional feature macro: IFETCH_BRCOUNT_EN
// ---------------------------------------------------------------------------
module inst_fetch_ctl #(
  parameter int PC_W        = 11,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            branch_en,
  input  logic            ALU_flag,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic            halt,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] prog_ctr,
  output logic            done,
  output logic            stack_ovf,
  output logic            stack_unf
`ifdef IFETCH_BRCOUNT_EN
  ,
  output logic [15:0]     br_count
`endif
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_ovf;
  logic              r_unf;
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [SP_W-1:0]   w_sp_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_br;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;
  logic [PC_W-1:0]   w_pop_data;

  // Sums are naturally modulo 2^PC_W; a negative offset in two's complement
  // wraps the same way as a plain unsigned add.
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_pc_br    = r_pc + target;
  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_pop_data = r_stack[w_pop_idx];

  // Next-state and datapath decisions. start overrides every state; inside
  // RUN only the highest-priority request acts in a given cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (start) begin
      w_state_nxt = S_LOAD;
      w_pc_nxt    = start_addr;
      w_sp_nxt    = '0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_LOAD: w_state_nxt = S_RUN;
        S_RUN: begin
          if (halt) begin
            w_state_nxt = S_DONE;
          end else if (ret_en) begin
            if (!w_empty) begin
              w_pc_nxt = w_pop_data;
              w_sp_nxt = r_sp - SP_W'(1);
            end else begin
              w_unf_nxt = 1'b1;
              w_pc_nxt  = w_pc_inc;
            end
          end else if (call_en) begin
            if (!w_full) begin
              w_push   = 1'b1;
              w_sp_nxt = r_sp + SP_W'(1);
              w_pc_nxt = target;
            end else begin
              w_ovf_nxt = 1'b1;
              w_pc_nxt  = w_pc_inc;
            end
          end else if (jump_en) begin
            w_pc_nxt = target;
          end else if (branch_en && ALU_flag) begin
            w_pc_nxt = w_pc_br;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
        S_DONE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_sp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Stack storage has no reset; entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign prog_ctr  = r_pc;
  assign done      = (r_state == S_DONE);
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

`ifdef IFETCH_BRCOUNT_EN
  logic        w_taken;
  logic [15:0] r_br_count;

  // A transfer counts only when it actually redirects the PC: failed calls
  // and returns, untaken branches and halts do not.
  always_comb begin
    w_taken = 1'b0;
    if (!start && r_state == S_RUN && !halt) begin
      if (ret_en)                      w_taken = !w_empty;
      else if (call_en)                w_taken = !w_full;
      else if (jump_en)                w_taken = 1'b1;
      else if (branch_en && ALU_flag)  w_taken = 1'b1;
    end
  end

  // Saturating transfer counter, cleared by reset and start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_count <= '0;
    end else if (start) begin
      r_br_count <= '0;
    end else if (w_taken && r_br_count != 16'hFFFF) begin
      r_br_count <= r_br_count + 16'd1;
    end
  end

  assign br_count = r_br_count;
`endif

endmodule

// File: tb/tb_inst_fetch_ctl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctl
// Scoreboard bench for inst_fetch_ctl. Stimulus is driven on the falling
// edge; a reference model written with plain integers and a queue-based
// stack predicts the state after the next rising edge and pushes it into an
// expectation queue. A separate monitor pops one entry per rising edge and
// compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctl;

  localparam int PCW   = 11;
  localparam int DEPTH = 4;
  localparam int PCMOD = 1 << PCW;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [PCW-1:0] start_addr;
  logic           branch_en;
  logic           ALU_flag;
  logic           jump_en;
  logic           call_en;
  logic           ret_en;
  logic           halt;
  logic [PCW-1:0] target;
  logic [PCW-1:0] prog_ctr;
  logic           done;
  logic           stack_ovf;
  logic           stack_unf;
`ifdef IFETCH_BRCOUNT_EN
  logic [15:0]    br_count;
`endif

  typedef struct {
    int pc;
    bit done;
    bit ovf;
    bit unf;
    int brc;
  } expect_t;

  expect_t expQ[$];
  int      checksDone   = 0;
  int      checksPassed = 0;

  int      mPc;
  int      mStack[$];
  int      mPhase;
  bit      mOvf;
  bit      mUnf;
  int      mBrc;

  inst_fetch_ctl #(
    .PC_W        (PCW),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .branch_en  (branch_en),
    .ALU_flag   (ALU_flag),
    .jump_en    (jump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .halt       (halt),
    .target     (target),
    .prog_ctr   (prog_ctr),
    .done       (done),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
`ifdef IFETCH_BRCOUNT_EN
    ,
    .br_count   (br_count)
`endif
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int act, input int exp);
    checksDone++;
    if (act == exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
  endtask

  function automatic void bumpBrc();
    if (mBrc < 65535) mBrc++;
  endfunction

  // Reference model: advance one clock using the fetch rules directly.
  task automatic modelStep(input bit rstn, input bit st, input int sa, input bit br,
                           input bit fl, input bit jp, input bit cl, input bit rt,
                           input bit ht, input int tg);
    int off;
    if (!rstn) begin
      mPc = 0; mStack.delete(); mPhase = P_IDLE; mOvf = 0; mUnf = 0; mBrc = 0;
    end else if (st) begin
      mPc = sa; mStack.delete(); mPhase = P_LOAD; mOvf = 0; mUnf = 0; mBrc = 0;
    end else if (mPhase == P_LOAD) begin
      mPhase = P_RUN;
    end else if (mPhase == P_RUN) begin
      if (ht) begin
        mPhase = P_DONE;
      end else if (rt) begin
        if (mStack.size() > 0) begin
          mPc = mStack.pop_back();
          bumpBrc();
        end else begin
          mUnf = 1;
          mPc  = (mPc + 1) % PCMOD;
        end
      end else if (cl) begin
        if (mStack.size() < DEPTH) begin
          mStack.push_back((mPc + 1) % PCMOD);
          mPc = tg;
          bumpBrc();
        end else begin
          mOvf = 1;
          mPc  = (mPc + 1) % PCMOD;
        end
      end else if (jp) begin
        mPc = tg;
        bumpBrc();
      end else if (br && fl) begin
        off = (tg >= PCMOD / 2) ? tg - PCMOD : tg;
        mPc = (mPc + off + PCMOD) % PCMOD;
        bumpBrc();
      end else begin
        mPc = (mPc + 1) % PCMOD;
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the prediction.
  task automatic applyStimulus(input bit rstn, input bit st, input int sa, input bit br,
                               input bit fl, input bit jp, input bit cl, input bit rt,
                               input bit ht, input int tg);
    expect_t e;
    @(negedge clk);
    reset      = rstn;
    start      = st;
    start_addr = PCW'(sa);
    branch_en  = br;
    ALU_flag   = fl;
    jump_en    = jp;
    call_en    = cl;
    ret_en     = rt;
    halt       = ht;
    target     = PCW'(tg);
    modelStep(rstn, st, sa, br, fl, jp, cl, rt, ht, tg);
    e.pc   = mPc;
    e.done = (mPhase == P_DONE);
    e.ovf  = mOvf;
    e.unf  = mUnf;
    e.brc  = mBrc;
    expQ.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doBranch(input bit fl, input int tg);
    applyStimulus(1, 0, 0, 1, fl, 0, 0, 0, 0, tg);
  endtask

  task automatic doJump(input int tg);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, tg);
  endtask

  task automatic doCall(input int tg);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, tg);
  endtask

  task automatic doRet();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: one expectation per rising edge, sampled just after the edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("prog_ctr", int'(prog_ctr), e.pc);
        checkOutput("done", int'(done), int'(e.done));
        checkOutput("stack_ovf", int'(stack_ovf), int'(e.ovf));
        checkOutput("stack_unf", int'(stack_unf), int'(e.unf));
`ifdef IFETCH_BRCOUNT_EN
        checkOutput("br_count", int'(br_count), e.brc);
`endif
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; start_addr = '0; branch_en = 1'b0; ALU_flag = 1'b0;
    jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; halt = 1'b0; target = '0;
    mPc = 0; mPhase = P_IDLE; mOvf = 0; mUnf = 0; mBrc = 0;

    // Reset held low with start asserted, then load address 5.
    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    tick(4);

    // Relative branches: forward, backward, and untaken.
    doBranch(1, 4);
    tick(2);
    doBranch(1, 11'h7FD);
    doBranch(0, 4);

    // Single call/return and an empty-stack return.
    doJump(20);
    doCall(100);
    tick(2);
    doRet();
    doRet();

    // Fill the stack, overflow, then unwind in LIFO order.
    doCall(200);
    doCall(300);
    doCall(400);
    doCall(500);
    doJump(50);
    doCall(999);
    for (int i = 0; i < 4; i++) doRet();

    // PC wrap at the top of the address space.
    doJump(PCMOD - 1);
    tick(1);

    // Simultaneous call and return: return wins.
    doCall(600);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 700);

    // Halt, then ignored jumps while done, then restart.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) doJump(300);
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    tick(1);

    // Mix of counted and uncounted transfers, then restart clears the count.
    doBranch(1, 3);
    doJump(30);
    doCall(80);
    doRet();
    doBranch(0, 7);
    applyStimulus(1, 1, 40, 0, 0, 0, 0, 0, 0, 0);
    tick(2);

    // Randomized traffic including occasional reset, start and halt.
    for (int i = 0; i < 3000; i++) begin
      bit rstn, st, br, fl, jp, cl, rt, ht;
      rstn = ($urandom_range(0, 199) != 0);
      st   = ($urandom_range(0, 99) < 2);
      ht   = ($urandom_range(0, 99) < 3);
      rt   = ($urandom_range(0, 99) < 15);
      cl   = ($urandom_range(0, 99) < 15);
      jp   = ($urandom_range(0, 99) < 10);
      br   = ($urandom_range(0, 99) < 30);
      fl   = $urandom_range(0, 1) == 1;
      applyStimulus(rstn, st, int'($urandom_range(0, PCMOD - 1)), br, fl, jp, cl, rt, ht,
                    int'($urandom_range(0, PCMOD - 1)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) checkOutput("scoreboard_drain", expQ.size(), 0);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctl.md
Name: inst_fetch_ctl

Overview:
- Parametrised next-generation program counter and fetch controller. Drives the instruction ROM address each cycle.
- Adds over the current fetch unit:
  - width-generic PC
  - signed relative branches and absolute jumps
  - hardware call/return stack with overflow/underflow flags
  - explicit IDLE/LOAD/RUN/DONE sequencing with a per-program start address and halt.
- Sits between the decoder/ALU flag path and InstROM.

Parameters:
- PC_W, 11, program counter and target width in bits.
- STACK_DEPTH, 4, call/return stack entries; power of 2, at least 2.
- SP_W, $clog2(STACK_DEPTH)+1, stack pointer width; holds 0..STACK_DEPTH.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  hold high to load start_addr; release to begin the program.
- start_addr  in  PC_W  first instruction address of the next program.
- branch_en  in  1  conditional relative branch request.
- ALU_flag  in  1  branch condition from ALU.
- jump_en  in  1  unconditional absolute jump to target.
- call_en  in  1  push PC+1, then jump absolute to target.
- ret_en  in  1  pop stack into PC.
- halt  in  1  program finished; freeze PC.
- target  in  PC_W  branch offset (two's complement) or absolute address.
- prog_ctr  out  PC_W  PC register; drives InstROM.
- done  out  1  high while in DONE.
- stack_ovf  out  1  sticky; a call was attempted with the stack full.
- stack_unf  out  1  sticky; a return was attempted with the stack empty.

Behaviour:
- Reset low, asynchronous: prog_ctr=0, sp=0, state=IDLE, done=0, stack_ovf=0, stack_unf=0. Stack contents are don't-care.
- start=1 in any state, highest priority after reset:
  - prog_ctr<=start_addr; sp<=0; flags cleared; done<=0; state<=LOAD.
- IDLE: PC held. Leaves only via start.
- LOAD with start=0: state<=RUN, PC unchanged. The instruction at start_addr gets exactly one RUN cycle.
- RUN, one action per cycle, in priority order:
  1. halt: state<=DONE, PC held.
  2. ret_en:
     - sp>0: PC<=stack[sp-1], sp<=sp-1.
     - sp=0: stack_unf<=1, PC<=PC+1.
  3. call_en:
     - sp<STACK_DEPTH: stack[sp]<=PC+1, sp<=sp+1, PC<=target.
     - Stack full: stack_ovf<=1, PC<=PC+1; no push, no jump.
  4. jump_en: PC<=target.
  5. branch_en && ALU_flag: PC<=PC+target, with target signed. branch_en with ALU_flag=0 falls through to PC+1.
  6. Otherwise PC<=PC+1.
- Arithmetic: all PC sums are modulo 2^PC_W. PC=2^PC_W-1 plus 1 gives 0; negative offsets wrap the same way.
- The latency of every PC update is one clock.
- DONE: done=1, PC held, all control inputs ignored until start.
- Control inputs outside RUN are ignored, except start.
- Reset mid-operation aborts immediately; state returns to IDLE with no completion.

Optional Feature:
- Macro IFETCH_BRCOUNT_EN.
- Defined:
  - Adds output br_count, 16 bits: count of taken control transfers (branch taken, jump, successful call, successful ret) since the last start or reset.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset low with start=1, start_addr=5 -> prog_ctr=0 while reset is low. Release reset, hold start 2 cycles -> prog_ctr=5. Drop start -> 5 for 1 cycle, then 6, 7, 8.
- At PC=8, branch_en=1, ALU_flag=1, target=4 -> PC=12. At PC=14, target=11'h7FD (-3) -> PC=11. branch_en=1, ALU_flag=0 -> PC+1.
- call_en at PC=20 with target=100 -> PC=100, sp=1. Run to 102, ret_en -> PC=21, sp=0. Repeat ret_en with sp=0 -> stack_unf=1, PC=22.
- Four nested calls, then a fifth call at PC=50 -> stack_ovf=1, PC=51, sp=4. Four returns unwind in LIFO order.
- PC=2047 with PC_W=11 -> next PC=0. call_en and ret_en together with sp=1 -> ret taken. halt -> done=1, PC frozen 5 cycles despite jump_en. start reclears done.
- With IFETCH_BRCOUNT_EN: 1 branch, 1 jump, 1 call, 1 ret, 1 untaken branch -> br_count=4. start -> br_count=0.
